cw_usb_bus_master: RTL and testbench



---
 rtl/cw_usbmaster_pkg.sv | 21 ++
 rtl/cw_usb_bus_master.sv | 241 ++++++++++++++++++++++++
 tb/tb_cw_usb_bus_master.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cw_usbmaster_pkg.sv
// cw_usbmaster_pkg
//   Shared types and widths for the SAM3U-style register bus initiator.
//   Contents:
//     USB_ADDR_W / USB_DATA_W : bus address and data widths
//     PHASE_CNT_W             : width of the per-phase down-counter
//     usb_state_e             : bus-cycle FSM states
package cw_usbmaster_pkg;

    localparam int USB_ADDR_W  = 8;
    localparam int USB_DATA_W  = 8;
    localparam int PHASE_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TURN   = 3'd4
    } usb_state_e;

endpackage

// File: rtl/cw_usb_bus_master.sv
// cw_usb_bus_master
//   Initiator for the SAM3U-style parallel register bus. Turns one
//   read/write command at a time into a timed bus cycle:
//     IDLE -> ADDR (SETUP_CYC) -> STROBE (STROBE_CYC) -> HOLD (HOLD_CYC)
//          -> [reads only] TURN (TURN_CYC) -> IDLE
//   All outputs come straight from flops.
//
//   Optional build macro CW_USBMASTER_BURST_EN: a command with the same
//   address and direction that is waiting during the last HOLD cycle is
//   accepted there and the FSM jumps straight back to STROBE, keeping
//   CEn low and ALEn high (streaming reads of a FIFO register).
//
//   Handshake: a command transfers on a rising edge where cmd_valid and
//   cmd_ready are both high; the requester must keep cmd_valid and the
//   cmd_* fields stable until that edge. rsp_valid is a one-cycle pulse.
//
//   Ports:
//     clk_usb, reset_i             clock, async active-high reset
//     cmd_valid/ready/write/addr/wdata   command port
//     rsp_valid/write/rdata        completion port (rdata held until next read)
//     busy                         high from acceptance until back in IDLE
//     USB_Addr, USB_D_o, USB_D_oe, USB_D_i   bus address and split data bus
//     USB_RDn, USB_WRn, USB_CEn, USB_ALEn    active-low strobes
module cw_usb_bus_master
    import cw_usbmaster_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1,
    parameter int TURN_CYC   = 2
) (
    input  logic                  clk_usb,
    input  logic                  reset_i,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [USB_ADDR_W-1:0] cmd_addr,
    input  logic [USB_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [USB_DATA_W-1:0] rsp_rdata,
    output logic                  busy,
    output logic [USB_ADDR_W-1:0] USB_Addr,
    output logic [USB_DATA_W-1:0] USB_D_o,
    output logic                  USB_D_oe,
    input  logic [USB_DATA_W-1:0] USB_D_i,
    output logic                  USB_RDn,
    output logic                  USB_WRn,
    output logic                  USB_CEn,
    output logic                  USB_ALEn
);

    generate
        if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
            HOLD_CYC < 1 || HOLD_CYC > 15 || TURN_CYC < 1 || TURN_CYC > 15) begin : g_bad_param
            $error("cw_usb_bus_master: phase lengths must be in 1..15");
        end
    endgenerate

    // Counter is loaded with length-1 on phase entry; phase ends when it reads 0.
    localparam logic [PHASE_CNT_W-1:0] SETUP_LD  = PHASE_CNT_W'(SETUP_CYC - 1);
    localparam logic [PHASE_CNT_W-1:0] STROBE_LD = PHASE_CNT_W'(STROBE_CYC - 1);
    localparam logic [PHASE_CNT_W-1:0] HOLD_LD   = PHASE_CNT_W'(HOLD_CYC - 1);
    localparam logic [PHASE_CNT_W-1:0] TURN_LD   = PHASE_CNT_W'(TURN_CYC - 1);

    usb_state_e              state_q, state_d;
    logic [PHASE_CNT_W-1:0]  cnt_q, cnt_d;
    logic                    write_q, write_d;     // direction of the command in flight
    logic [USB_ADDR_W-1:0]   addr_q, addr_d;       // doubles as the latched command address
    logic [USB_DATA_W-1:0]   d_o_q, d_o_d;
    logic                    d_oe_q, d_oe_d;
    logic                    rdn_q, rdn_d, wrn_q, wrn_d, cen_q, cen_d, alen_q, alen_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic [USB_DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    busy_q, busy_d;

`ifdef CW_USBMASTER_BURST_EN
    logic burst_match;
    assign burst_match = (cmd_addr == addr_q) && (cmd_write == write_q);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        d_o_d       = d_o_q;
        d_oe_d      = d_oe_q;
        rdn_d       = rdn_q;
        wrn_d       = wrn_q;
        cen_d       = cen_q;
        alen_d      = alen_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                // cmd_ready_q is the registered ready, so the first IDLE
                // cycle after reset does not accept anything.
                if (cmd_valid && cmd_ready_q) begin
                    state_d = ST_ADDR;
                    cnt_d   = SETUP_LD;
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    d_o_d   = cmd_wdata;
                    d_oe_d  = cmd_write;
                    cen_d   = 1'b0;
                    alen_d  = 1'b0;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ST_ADDR: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                    alen_d  = 1'b1;
                    wrn_d   = ~write_q;
                    rdn_d   = write_q;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d     = ST_HOLD;
                    cnt_d       = HOLD_LD;
                    rdn_d       = 1'b1;
                    wrn_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = write_q;
                    if (!write_q) begin
                        rsp_rdata_d = USB_D_i;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
`ifdef CW_USBMASTER_BURST_EN
                    if (cmd_valid && cmd_ready_q && burst_match) begin
                        state_d = ST_STROBE;
                        cnt_d   = STROBE_LD;
                        d_o_d   = cmd_wdata;
                        wrn_d   = ~write_q;
                        rdn_d   = write_q;
                    end else
`endif
                    if (write_q) begin
                        state_d     = ST_IDLE;
                        cen_d       = 1'b1;
                        d_oe_d      = 1'b0;
                        cmd_ready_d = 1'b1;
                    end else begin
                        state_d = ST_TURN;
                        cnt_d   = TURN_LD;
                        cen_d   = 1'b1;
                        d_oe_d  = 1'b0;
                    end
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef CW_USBMASTER_BURST_EN
        // Ready is registered, so it is raised one edge early for the last
        // HOLD cycle when a matching command is already waiting; the held
        // valid/fields keep it matching through the accepting edge.
        if (state_d == ST_HOLD && cnt_d == '0 && cmd_valid && burst_match) begin
            cmd_ready_d = 1'b1;
        end
`endif

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            d_o_q       <= '0;
            d_oe_q      <= 1'b0;
            rdn_q       <= 1'b1;
            wrn_q       <= 1'b1;
            cen_q       <= 1'b1;
            alen_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            d_o_q       <= d_o_d;
            d_oe_q      <= d_oe_d;
            rdn_q       <= rdn_d;
            wrn_q       <= wrn_d;
            cen_q       <= cen_d;
            alen_q      <= alen_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign USB_Addr  = addr_q;
    assign USB_D_o   = d_o_q;
    assign USB_D_oe  = d_oe_q;
    assign USB_RDn   = rdn_q;
    assign USB_WRn   = wrn_q;
    assign USB_CEn   = cen_q;
    assign USB_ALEn  = alen_q;

    a_no_dual_strobe: assert property (@(posedge clk_usb) disable iff (reset_i)
        !(!rdn_q && !wrn_q));
    a_doe_only_write: assert property (@(posedge clk_usb) disable iff (reset_i)
        d_oe_q |-> (!cen_q && write_q));
    a_ale_only_addr: assert property (@(posedge clk_usb) disable iff (reset_i)
        !alen_q |-> (state_q == ST_ADDR));

endmodule

// File: tb/tb_cw_usb_bus_master.sv
// tb_cw_usb_bus_master
//   Directed bench for cw_usb_bus_master. Three instances share the command
//   inputs: u_dut (defaults 2/3/1/2) is checked cycle by cycle, u_fast
//   (1/1/1/1) and u_slow (15/15/15/15) are checked through measured phase
//   widths. A simple slave drives slave_data on USB_D_i while RDn is low.
module tb_cw_usb_bus_master;

    logic       clk_usb = 1'b0;
    logic       reset_i = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr  = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic [7:0] slave_data = 8'h00;
    logic       clr = 1'b0;

    logic [2:0] ready_w, rv_w, rw_w, busy_w, d_oe_w, rdn_w, wrn_w, cen_w, alen_w;
    logic [7:0] rdata_w [3];
    logic [7:0] addr_w  [3];
    logic [7:0] d_o_w   [3];
    logic [7:0] d_i_w   [3];

    int checks = 0;
    int failures = 0;

    // expected phase lengths per instance: setup, strobe, hold, turn
    int p_s [3] = '{2, 1, 15};
    int p_t [3] = '{3, 1, 15};
    int p_h [3] = '{1, 1, 15};
    int p_u [3] = '{2, 1, 15};

    // per-instance measured widths (cycles sampled at rising edges)
    int ale_lo [3];
    int str_lo [3];
    int ce_lo  [3];
    int busy_hi[3];
    int rv_n   [3];
    // u_dut only
    int ale_fall, rd_fall, ce_fall, hs_n, overlap_n;
    logic alen_p, rdn_p, cen_p;

    // {ALEn, RDn, WRn, CEn, D_oe, busy, cmd_ready, rsp_valid} of u_dut
    logic [7:0] mon0;
    assign mon0 = {alen_w[0], rdn_w[0], wrn_w[0], cen_w[0], d_oe_w[0], busy_w[0], ready_w[0], rv_w[0]};

    logic [7:0] exp_wr [7] = '{8'b01101100, 8'b01101100, 8'b11001100, 8'b11001100,
                               8'b11001100, 8'b11101101, 8'b11110010};
    logic [7:0] exp_rd [9] = '{8'b01100100, 8'b01100100, 8'b10100100, 8'b10100100,
                               8'b10100100, 8'b11100101, 8'b11110100, 8'b11110100,
                               8'b11110010};

    always #5 clk_usb = ~clk_usb;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            d_i_w[k] = rdn_w[k] ? 8'h00 : slave_data;
        end
    end

    cw_usb_bus_master #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1), .TURN_CYC(2)) u_dut (
        .clk_usb(clk_usb), .reset_i(reset_i),
        .cmd_valid(cmd_valid), .cmd_ready(ready_w[0]), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv_w[0]), .rsp_write(rw_w[0]), .rsp_rdata(rdata_w[0]), .busy(busy_w[0]),
        .USB_Addr(addr_w[0]), .USB_D_o(d_o_w[0]), .USB_D_oe(d_oe_w[0]), .USB_D_i(d_i_w[0]),
        .USB_RDn(rdn_w[0]), .USB_WRn(wrn_w[0]), .USB_CEn(cen_w[0]), .USB_ALEn(alen_w[0]));

    cw_usb_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .TURN_CYC(1)) u_fast (
        .clk_usb(clk_usb), .reset_i(reset_i),
        .cmd_valid(cmd_valid), .cmd_ready(ready_w[1]), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv_w[1]), .rsp_write(rw_w[1]), .rsp_rdata(rdata_w[1]), .busy(busy_w[1]),
        .USB_Addr(addr_w[1]), .USB_D_o(d_o_w[1]), .USB_D_oe(d_oe_w[1]), .USB_D_i(d_i_w[1]),
        .USB_RDn(rdn_w[1]), .USB_WRn(wrn_w[1]), .USB_CEn(cen_w[1]), .USB_ALEn(alen_w[1]));

    cw_usb_bus_master #(.SETUP_CYC(15), .STROBE_CYC(15), .HOLD_CYC(15), .TURN_CYC(15)) u_slow (
        .clk_usb(clk_usb), .reset_i(reset_i),
        .cmd_valid(cmd_valid), .cmd_ready(ready_w[2]), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv_w[2]), .rsp_write(rw_w[2]), .rsp_rdata(rdata_w[2]), .busy(busy_w[2]),
        .USB_Addr(addr_w[2]), .USB_D_o(d_o_w[2]), .USB_D_oe(d_oe_w[2]), .USB_D_i(d_i_w[2]),
        .USB_RDn(rdn_w[2]), .USB_WRn(wrn_w[2]), .USB_CEn(cen_w[2]), .USB_ALEn(alen_w[2]));

    // width / event monitor
    always @(posedge clk_usb) begin
        if (clr) begin
            for (int k = 0; k < 3; k++) begin
                ale_lo[k]  <= 0;
                str_lo[k]  <= 0;
                ce_lo[k]   <= 0;
                busy_hi[k] <= 0;
                rv_n[k]    <= 0;
            end
            ale_fall <= 0;
            rd_fall  <= 0;
            ce_fall  <= 0;
            hs_n     <= 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                ale_lo[k]  <= ale_lo[k]  + 32'(!alen_w[k]);
                str_lo[k]  <= str_lo[k]  + 32'(!rdn_w[k] || !wrn_w[k]);
                ce_lo[k]   <= ce_lo[k]   + 32'(!cen_w[k]);
                busy_hi[k] <= busy_hi[k] + 32'(busy_w[k]);
                rv_n[k]    <= rv_n[k]    + 32'(rv_w[k]);
            end
            ale_fall <= ale_fall + 32'(alen_p && !alen_w[0]);
            rd_fall  <= rd_fall  + 32'(rdn_p && !rdn_w[0]);
            ce_fall  <= ce_fall  + 32'(cen_p && !cen_w[0]);
            hs_n     <= hs_n     + 32'(cmd_valid && ready_w[0]);
        end
        overlap_n <= overlap_n + 32'(d_oe_w[0] && !rdn_w[0]);
        alen_p <= alen_w[0];
        rdn_p  <= rdn_w[0];
        cen_p  <= cen_w[0];
    end

    task automatic tick;
        @(posedge clk_usb);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_all_idle(input string tag);
        int n;
        n = 0;
        while (!(ready_w == 3'b111 && busy_w == 3'b000) && n < 400) begin
            tick();
            n++;
        end
        check(tag, 32'(ready_w == 3'b111 && busy_w == 3'b000), 32'd1);
    endtask

    task automatic clear_counters;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        overlap_n = 0;
        alen_p = 1'b1;
        rdn_p  = 1'b1;
        cen_p  = 1'b1;

        // ---- reset values
        tick();
        tick();
        check("rst_mon", 32'(mon0), 32'h0000_00F0);
        check("rst_addr", 32'(addr_w[0]), 32'h0);
        check("rst_d_o", 32'(d_o_w[0]), 32'h0);
        check("rst_rdata", 32'(rdata_w[0]), 32'h0);
        check("rst_rsp_write", 32'(rw_w[0]), 32'h0);
        reset_i = 1'b0;
        tick();
        check("rst_rel_ready", 32'(ready_w), 32'h7);

        // ---- write 0x21 <- 0x5A
        clear_counters();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h21; cmd_wdata = 8'h5A;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) begin
                cmd_valid = 1'b0;
                check("wr_addr", 32'(addr_w[0]), 32'h21);
                check("wr_d_o", 32'(d_o_w[0]), 32'h5A);
            end
            check($sformatf("wr_phase%0d", i), 32'(mon0), 32'(exp_wr[i]));
            if (i == 5) check("wr_rsp_write", 32'(rw_w[0]), 32'h1);
        end
        wait_all_idle("wr_idle");
        for (int k = 0; k < 3; k++) begin
            check($sformatf("wr_ale_w%0d", k), 32'(ale_lo[k]), 32'(p_s[k]));
            check($sformatf("wr_str_w%0d", k), 32'(str_lo[k]), 32'(p_t[k]));
            check($sformatf("wr_ce_w%0d", k), 32'(ce_lo[k]), 32'(p_s[k] + p_t[k] + p_h[k]));
            check($sformatf("wr_busy_w%0d", k), 32'(busy_hi[k]), 32'(p_s[k] + p_t[k] + p_h[k]));
            check($sformatf("wr_rsp_n%0d", k), 32'(rv_n[k]), 32'd1);
        end

        // ---- read 0x04, slave returns 0xC3
        clear_counters();
        slave_data = 8'hC3;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h04; cmd_wdata = 8'hEE;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 0) begin
                cmd_valid = 1'b0;
                check("rd_addr", 32'(addr_w[0]), 32'h04);
            end
            check($sformatf("rd_phase%0d", i), 32'(mon0), 32'(exp_rd[i]));
            if (i == 5) check("rd_rdata", 32'(rdata_w[0]), 32'hC3);
        end
        wait_all_idle("rd_idle");
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rd_ale_w%0d", k), 32'(ale_lo[k]), 32'(p_s[k]));
            check($sformatf("rd_str_w%0d", k), 32'(str_lo[k]), 32'(p_t[k]));
            check($sformatf("rd_ce_w%0d", k), 32'(ce_lo[k]), 32'(p_s[k] + p_t[k] + p_h[k]));
            check($sformatf("rd_turn_w%0d", k), 32'(busy_hi[k] - ce_lo[k]), 32'(p_u[k]));
            check($sformatf("rd_data%0d", k), 32'(rdata_w[k]), 32'hC3);
        end

        // ---- back-to-back write then read of 0x10 with valid held
        slave_data = 8'h3C;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'h77;
        tick();
        cmd_write = 1'b0; cmd_wdata = 8'h00;
        for (int i = 1; i < 7; i++) tick();
        check("b2b_gap", 32'(mon0), 32'h0000_00F2);
        tick();
        check("b2b_rd_start", 32'(mon0), 32'h0000_0064);
        cmd_valid = 1'b0;
        wait_all_idle("b2b_idle");
        check("b2b_rdata", 32'(rdata_w[0]), 32'h3C);
        check("b2b_rsp_write", 32'(rw_w[0]), 32'h0);

        // ---- reset during STROBE of a write
        clear_counters();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'hAA;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("rstw_pre", 32'(mon0), 32'h0000_00CC);
        #2 reset_i = 1'b1;
        #1 check("rstw_async", 32'(mon0), 32'h0000_00F0);
        tick();
        reset_i = 1'b0;
        check("rstw_no_rsp", 32'(rv_n[0]), 32'd0);
        check("rstw_rdata", 32'(rdata_w[0]), 32'h0);
        tick();
        check("rstw_ready", 32'(ready_w[0]), 32'h1);
        wait_all_idle("rstw_idle");

`ifdef CW_USBMASTER_BURST_EN
        // ---- burst: 4 reads of 0x03
        clear_counters();
        slave_data = 8'h99;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h03;
        for (int i = 0; i < 100 && hs_n < 4; i++) tick();
        cmd_valid = 1'b0;
        check("bst_handshakes", 32'(hs_n), 32'd4);
        wait_all_idle("bst_idle");
        check("bst_ale_pulses", 32'(ale_fall), 32'd1);
        check("bst_rd_pulses", 32'(rd_fall), 32'd4);
        check("bst_ce_pulses", 32'(ce_fall), 32'd1);
        check("bst_ce_width", 32'(ce_lo[0]), 32'd18);
        check("bst_rsp_n", 32'(rv_n[0]), 32'd4);
        check("bst_rdata", 32'(rdata_w[0]), 32'h99);
`endif

        check("no_doe_rd_overlap", 32'(overlap_n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
